// File: rtl/bram_fifo.sv
// Single-clock FIFO on one 4 Kbit block RAM; DATA_WIDTH picks the RAM geometry.
// Define BRAM_FIFO_STATUS_EN to add sticky overflow/underflow outputs.
module bram_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    output logic                                  full,
    output logic                                  almost_full,
    input  logic                                  rd_en,
    output logic [DATA_WIDTH-1:0]                 rd_data,
    output logic                                  rd_valid,
    output logic                                  empty,
    output logic [$clog2(4096/DATA_WIDTH):0]      count
`ifdef BRAM_FIFO_STATUS_EN
    ,
    output logic                                  overflow,
    output logic                                  underflow
`endif
);
    localparam int DEPTH  = 4096 / DATA_WIDTH;
    localparam int AW     = $clog2(DEPTH);
    localparam int MODE   = (DATA_WIDTH == 16) ? 0 : (DATA_WIDTH == 8) ? 1 : (DATA_WIDTH == 4) ? 2 : 3;
    localparam int STRIDE = 1 << MODE;
    localparam int OFFSET = (MODE == 2) ? 1 : (MODE == 3) ? 3 : 0;

    if (!(DATA_WIDTH == 16 || DATA_WIDTH == 8 || DATA_WIDTH == 4 || DATA_WIDTH == 2)) begin : g_bad_width
        $error("bram_fifo: DATA_WIDTH must be 16, 8, 4 or 2");
    end
    if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("bram_fifo: AFULL_MARGIN out of range");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d, full_q, full_d, afull_q, afull_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_acc, rd_acc;
    logic [10:0]   waddr, raddr;
    logic [15:0]   wdata_bus, rd_bus;
    logic [15:0]   mem [0:2047];
    logic          rd_bus_unused;

    always_comb begin
        wr_acc     = wr_en & ~full_q;
        rd_acc     = rd_en & ~empty_q;
        wr_ptr_d   = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        empty_d    = (count_d == '0);
        full_d     = (count_d == (AW+1)'(DEPTH));
        afull_d    = (count_d >= (AW+1)'(DEPTH - AFULL_MARGIN));
        rd_valid_d = rd_acc;
        waddr      = 11'(wr_ptr_q);
        raddr      = 11'(rd_ptr_q);
    end

    // Word bits sit on the RAM data lanes that the selected mode actually uses.
    always_comb begin
        wdata_bus = '0;
        rd_data   = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            wdata_bus[STRIDE*i+OFFSET] = wr_data[i];
            rd_data[i]                 = rd_bus[STRIDE*i+OFFSET];
        end
    end
    assign rd_bus_unused = ^rd_bus;

    // Block RAM: contents survive reset, read port registered.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[waddr] <= wdata_bus;
        if (rd_acc) rd_bus <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign full        = full_q;
    assign almost_full = afull_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign rd_valid    = rd_valid_q;

`ifdef BRAM_FIFO_STATUS_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (wr_en & full_q);
        underflow_d = underflow_q | (rd_en & empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif
endmodule

// File: tb/tb_bram_fifo.sv
// Bench for bram_fifo: fixed vector table, queue-model checked sequences and
// random traffic on an 8-bit instance, plus a 2-bit instance for lane mapping.
module tb_bram_fifo;
    localparam int DEPTH  = 512;
    localparam int MARGIN = 4;

    logic       clk;
    logic       rst, wr_en, rd_en;
    logic [7:0] wr_data, rd_data;
    logic       full, almost_full, rd_valid, empty;
    logic [9:0] count;

    logic       b_rst, b_wr, b_rd;
    logic [1:0] b_din, b_dout;
    logic       b_full, b_afull, b_valid, b_empty;
    logic [11:0] b_count;

`ifdef BRAM_FIFO_STATUS_EN
    logic ovf, unf, b_ovf, b_unf;
    logic m_ovf, m_unf;
`endif

    int n_vec, n_fail;
    logic [7:0] q[$];
    logic       ev;
    logic [7:0] ed;

    bram_fifo #(.DATA_WIDTH(8), .AFULL_MARGIN(MARGIN)) dut (
        .clk(clk),
`ifdef BRAM_FIFO_STATUS_EN
        .overflow(ovf), .underflow(unf),
`endif
        .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .count(count)
    );

    bram_fifo #(.DATA_WIDTH(2)) dut2 (
        .clk(clk),
`ifdef BRAM_FIFO_STATUS_EN
        .overflow(b_ovf), .underflow(b_unf),
`endif
        .rst(b_rst), .wr_en(b_wr), .wr_data(b_din), .full(b_full),
        .almost_full(b_afull), .rd_en(b_rd), .rd_data(b_dout),
        .rd_valid(b_valid), .empty(b_empty), .count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the queue model by the FIFO rules, compare.
    task automatic mstep(input logic r, input logic w, input logic rr, input logic [7:0] d);
        logic e, f;
        rst = r; wr_en = w; rd_en = rr; wr_data = d;
        if (r) begin
            q.delete();
            ev = 1'b0;
`ifdef BRAM_FIFO_STATUS_EN
            m_ovf = 1'b0; m_unf = 1'b0;
`endif
        end else begin
            e  = (q.size() == 0);
            f  = (q.size() == DEPTH);
            ev = 1'b0;
            if (rr && !e) begin ed = q.pop_front(); ev = 1'b1; end
            if (w && !f) q.push_back(d);
`ifdef BRAM_FIFO_STATUS_EN
            if (w && f) m_ovf = 1'b1;
            if (rr && e) m_unf = 1'b1;
`endif
        end
        @(posedge clk); #1;
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - MARGIN));
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        if (ev) chk("rd_data", 32'(rd_data), 32'(ed));
`ifdef BRAM_FIFO_STATUS_EN
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("underflow", 32'(unf), 32'(m_unf));
`endif
    endtask

    typedef struct {
        logic       rst, wr, rd;
        logic [7:0] din;
        int         cnt;
        logic       emp, ful, vld;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl [10];

    initial begin
        n_vec = 0; n_fail = 0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
        ev = 1'b0; ed = '0;
`ifdef BRAM_FIFO_STATUS_EN
        m_ovf = 1'b0; m_unf = 1'b0;
`endif
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h3C, 2, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h77, 1, 1'b0, 1'b0, 1'b1, 8'h3C};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h77};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h11, 1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h11};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00};

        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst; wr_en = tbl[i].wr; rd_en = tbl[i].rd; wr_data = tbl[i].din;
            @(posedge clk); #1;
            chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
            chk("tbl_empty", 32'(empty), 32'(tbl[i].emp));
            chk("tbl_full", 32'(full), 32'(tbl[i].ful));
            chk("tbl_rd_valid", 32'(rd_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) chk("tbl_rd_data", 32'(rd_data), 32'(tbl[i].dout));
        end

        // Fill past capacity: last write must be dropped.
        mstep(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i <= DEPTH; i++) mstep(1'b0, 1'b1, 1'b0, 8'(i));
        chk("fill_full", 32'(full), 32'd1);

        // Full with both requests: count pinned, stream contiguous across wrap.
        for (int i = 0; i < 1200; i++) mstep(1'b0, 1'b1, 1'b1, 8'(i + 100));
        for (int i = 0; i < DEPTH + 8; i++) mstep(1'b0, 1'b0, 1'b1, 8'h00);
        chk("drain_empty", 32'(empty), 32'd1);

        // Reset with words stored and a read pending.
        for (int i = 0; i < 5; i++) mstep(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        mstep(1'b1, 1'b0, 1'b1, 8'h00);
        chk("rst_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) mstep(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
        for (int i = 0; i < 4; i++) mstep(1'b0, 1'b0, 1'b1, 8'h00);

        // Random traffic in phases of differing fill pressure.
        for (int p = 0; p < 4; p++) begin
            int pw, pr;
            pw = (p == 0) ? 90 : (p == 1) ? 20 : (p == 2) ? 50 : 95;
            pr = (p == 0) ? 10 : (p == 1) ? 80 : (p == 2) ? 50 : 95;
            for (int i = 0; i < 800; i++)
                mstep(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) < pw),
                      ($urandom_range(0, 99) < pr), 8'($urandom));
        end

        // 2-bit instance: lanes 3 and 11 of the RAM word.
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk); #1;
        b_rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            b_wr = 1'b1; b_din = 2'(i);
            @(posedge clk); #1;
        end
        b_wr = 1'b0;
        chk("w2_count", 32'(b_count), 32'd3);
        b_rd = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk("w2_rd_valid", 32'(b_valid), 32'd1);
            chk("w2_rd_data", 32'(b_dout), 32'(i));
        end
        b_rd = 1'b0;
        @(posedge clk); #1;
        chk("w2_idle_valid", 32'(b_valid), 32'd0);
        chk("w2_empty", 32'(b_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
